// File: rtl/audio_pkg.sv
// Shared types and helpers for the stereo audio mixer.
//   mix_state_t : states of the mix sequencer
//   gain_t      : per-channel attenuation, a right shift of 0..7
//   acc_width() : accumulator width that can hold N full-scale channels plus the speaker term
package audio_pkg;

   typedef enum logic [1:0] {IDLE, ACCUM, SAT, OUT} mix_state_t;

   typedef logic [2:0] gain_t;

   function automatic int acc_width(input int out_w, input int n);
      return out_w + $clog2(n + 2);
   endfunction

endpackage

// File: rtl/speaker_pulse.sv
// Speaker pulse stretcher.
// Turns every level change of the speaker flip-flop into a pulse that lasts
// SPK_HOLD sample periods, so that short clicks remain audible in the mix.
// Ports:
//   clk        in  logic clock
//   reset      in  asynchronous, active-high
//   speaker_i  in  speaker flip-flop level (clk domain)
//   strobe_i   in  one pulse per sample period
//   active_o   out speaker level is high and the hold window is still open
module speaker_pulse
   import audio_pkg::*;
#(
   parameter int SPK_HOLD = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic speaker_i,
   input  logic strobe_i,
   output logic active_o
);

   localparam int HW = (SPK_HOLD < 2) ? 1 : $clog2(SPK_HOLD + 1);

   logic [HW-1:0] hold;
   logic          speaker_prev;

   // Edge detection runs on every clk; a toggle coinciding with a strobe
   // reloads the window rather than letting the strobe shorten it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold         <= '0;
         speaker_prev <= 1'b0;
      end else begin
         speaker_prev <= speaker_i;
         if (speaker_i != speaker_prev) begin
            hold <= HW'(SPK_HOLD);
         end else if (strobe_i && (hold != '0)) begin
            hold <= hold - HW'(1);
         end
      end
   end

   assign active_o = speaker_prev && (hold != '0);

endmodule

// File: rtl/audio_mixer.sv
// N-channel stereo audio mixer for the HDMI audio path.
// Generates the audio sample strobe from clk, then mixes one channel per
// cycle into wide accumulators (gain shift, mute, speaker pulse), saturates
// to OUT_WIDTH and registers one stereo sample per sample period.
// Ports:
//   clk, reset      clock and asynchronous active-high reset
//   speaker_i       speaker flip-flop level (clk domain)
//   speaker_en_i    1 = speaker pulse contributes to the mix
//   ch_l_i/ch_r_i   unsigned samples, channel k at [k*IN_WIDTH +: IN_WIDTH]
//   ch_gain_i       per-channel right shift, channel k at [k*3 +: 3]
//   ch_mute_i       1 = channel contributes 0
//   audio_strobe_o  one-cycle pulse per sample period
//   sample_l_o/_r_o mixed sample, held between updates
//   sample_valid_o  one-cycle pulse when the samples update
//   clip_o          pulses with sample_valid_o if either side saturated
//
// state | meaning
// IDLE  | waiting for the sample strobe; preload accumulators with speaker term
// ACCUM | add one channel per cycle, channel index ch_idx
// SAT   | clamp each accumulator to full scale, note clipping
// OUT   | register the stereo sample and pulse valid/clip
module audio_mixer
   import audio_pkg::*;
#(
   parameter int                   CLOCK_SPEED_HZ = 54_000_000,
   parameter int                   AUDIO_RATE     = 44100,
   parameter int                   NUM_CH         = 4,
   parameter int                   IN_WIDTH       = 10,
   parameter int                   OUT_WIDTH      = 16,
   parameter int                   SPK_HOLD       = 255,
   parameter logic [OUT_WIDTH-1:0] SPK_LEVEL      = 16'h2000
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         speaker_i,
   input  logic                         speaker_en_i,
   input  logic [NUM_CH*IN_WIDTH-1:0]   ch_l_i,
   input  logic [NUM_CH*IN_WIDTH-1:0]   ch_r_i,
   input  logic [NUM_CH*3-1:0]          ch_gain_i,
   input  logic [NUM_CH-1:0]            ch_mute_i,
   output logic                         audio_strobe_o,
   output logic [OUT_WIDTH-1:0]         sample_l_o,
   output logic [OUT_WIDTH-1:0]         sample_r_o,
   output logic                         sample_valid_o,
   output logic                         clip_o
);

   localparam int DIV   = CLOCK_SPEED_HZ / AUDIO_RATE;
   localparam int ACC_W = acc_width(OUT_WIDTH, NUM_CH);
   localparam int DW    = (DIV < 2) ? 1 : $clog2(DIV);
   localparam int CW    = (NUM_CH < 2) ? 1 : $clog2(NUM_CH);
   localparam logic [ACC_W-1:0] FULL = ACC_W'({OUT_WIDTH{1'b1}});

   // The mix must finish inside one sample period, so a strobe can only
   // ever arrive while the sequencer is idle.
   if (DIV < NUM_CH + 4) begin : g_div_too_small
      $error("audio_mixer: sample period too short for NUM_CH channels");
   end
   if (IN_WIDTH > OUT_WIDTH) begin : g_in_too_wide
      $error("audio_mixer: IN_WIDTH must not exceed OUT_WIDTH");
   end
   if ((NUM_CH < 1) || (NUM_CH > 8)) begin : g_bad_num_ch
      $error("audio_mixer: NUM_CH must be 1..8");
   end

   mix_state_t       state, state_nxt;
   logic [DW-1:0]    div_cnt;
   logic [CW-1:0]    ch_idx;
   logic [ACC_W-1:0] acc_l, acc_r;
   logic             clip_l, clip_r;
   logic             spk_active;
   logic [ACC_W-1:0] spk_term;

   logic [IN_WIDTH-1:0]  sel_l, sel_r;
   gain_t                sel_gain;
   logic                 sel_mute;
   logic [OUT_WIDTH-1:0] wide_l, wide_r;
   logic [ACC_W-1:0]     x_l, x_r;

   // sample-rate divider
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
      end else if (div_cnt == DW'(DIV - 1)) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + DW'(1);
      end
   end

   assign audio_strobe_o = (div_cnt == DW'(DIV - 1));

   speaker_pulse #(
      .SPK_HOLD (SPK_HOLD)
   ) u_speaker_pulse (
      .clk       (clk),
      .reset     (reset),
      .speaker_i (speaker_i),
      .strobe_i  (audio_strobe_o),
      .active_o  (spk_active)
   );

   assign spk_term = (speaker_en_i && spk_active) ? ACC_W'(SPK_LEVEL) : '0;

   // Current channel is read live in its ACCUM cycle; inputs are not snapshotted.
   always_comb begin
      sel_l    = '0;
      sel_r    = '0;
      sel_gain = '0;
      sel_mute = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (ch_idx == CW'(k)) begin
            sel_l    = ch_l_i[k*IN_WIDTH +: IN_WIDTH];
            sel_r    = ch_r_i[k*IN_WIDTH +: IN_WIDTH];
            sel_gain = ch_gain_i[k*3 +: 3];
            sel_mute = ch_mute_i[k];
         end
      end
      // left-justify to full scale, then attenuate
      wide_l = OUT_WIDTH'(sel_l) << (OUT_WIDTH - IN_WIDTH);
      wide_r = OUT_WIDTH'(sel_r) << (OUT_WIDTH - IN_WIDTH);
      x_l    = sel_mute ? '0 : ACC_W'(wide_l >> sel_gain);
      x_r    = sel_mute ? '0 : ACC_W'(wide_r >> sel_gain);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (audio_strobe_o) state_nxt = ACCUM;
         ACCUM:   if (ch_idx == CW'(NUM_CH - 1)) state_nxt = SAT;
         SAT:     state_nxt = OUT;
         OUT:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_l          <= '0;
         acc_r          <= '0;
         ch_idx         <= '0;
         clip_l         <= 1'b0;
         clip_r         <= 1'b0;
         sample_l_o     <= '0;
         sample_r_o     <= '0;
         sample_valid_o <= 1'b0;
         clip_o         <= 1'b0;
      end else begin
         sample_valid_o <= 1'b0;
         clip_o         <= 1'b0;
         case (state)
            IDLE: begin
               if (audio_strobe_o) begin
                  acc_l  <= spk_term;
                  acc_r  <= spk_term;
                  ch_idx <= '0;
                  clip_l <= 1'b0;
                  clip_r <= 1'b0;
               end
            end
            ACCUM: begin
               acc_l  <= acc_l + x_l;
               acc_r  <= acc_r + x_r;
               ch_idx <= ch_idx + CW'(1);
            end
            SAT: begin
               if (acc_l > FULL) begin
                  acc_l  <= FULL;
                  clip_l <= 1'b1;
               end
               if (acc_r > FULL) begin
                  acc_r  <= FULL;
                  clip_r <= 1'b1;
               end
            end
            OUT: begin
               sample_l_o     <= acc_l[OUT_WIDTH-1:0];
               sample_r_o     <= acc_r[OUT_WIDTH-1:0];
               sample_valid_o <= 1'b1;
               clip_o         <= clip_l | clip_r;
            end
            default: ;
         endcase
      end
   end

   // A strobe outside IDLE would mean the divider is too short; it is ignored.
   strobe_only_in_idle: assert property (
      @(posedge clk) disable iff (reset) audio_strobe_o |-> (state == IDLE)
   );

endmodule

// File: tb/tb_audio_mixer.sv
// Self-checking bench for audio_mixer.
// Two instances: one with default parameters (strobe period, silent mix),
// one with a 16-clock sample period so long speaker windows stay short in
// simulation. Expected samples come from an arithmetic model of the mix.
module tb_audio_mixer;

   localparam int NCH    = 4;
   localparam int INW    = 10;
   localparam int OUTW   = 16;
   localparam int HOLD   = 255;
   localparam int F_DIV  = 16;
   localparam int D_DIV  = 54_000_000 / 44100;
   localparam int SPKLVL = 'h2000;

   logic clk = 1'b0;
   logic rst = 1'b1;

   // fast instance
   logic                  spk = 1'b0;
   logic                  spk_en = 1'b0;
   logic [NCH*INW-1:0]    ch_l = '0;
   logic [NCH*INW-1:0]    ch_r = '0;
   logic [NCH*3-1:0]      ch_gain = '0;
   logic [NCH-1:0]        ch_mute = '0;
   logic                  strobe, valid, clip;
   logic [OUTW-1:0]       sl, sr;

   // default instance, inputs held at 0
   logic                  d_spk = 1'b0;
   logic                  d_spk_en = 1'b0;
   logic [NCH*INW-1:0]    d_ch_l = '0;
   logic [NCH*INW-1:0]    d_ch_r = '0;
   logic [NCH*3-1:0]      d_ch_gain = '0;
   logic [NCH-1:0]        d_ch_mute = '0;
   logic                  d_strobe, d_valid, d_clip;
   logic [OUTW-1:0]       d_sl, d_sr;

   always #5 clk = ~clk;

   audio_mixer #(
      .CLOCK_SPEED_HZ (44100 * F_DIV),
      .AUDIO_RATE     (44100)
   ) dut (
      .clk            (clk),
      .reset          (rst),
      .speaker_i      (spk),
      .speaker_en_i   (spk_en),
      .ch_l_i         (ch_l),
      .ch_r_i         (ch_r),
      .ch_gain_i      (ch_gain),
      .ch_mute_i      (ch_mute),
      .audio_strobe_o (strobe),
      .sample_l_o     (sl),
      .sample_r_o     (sr),
      .sample_valid_o (valid),
      .clip_o         (clip)
   );

   audio_mixer dut_dflt (
      .clk            (clk),
      .reset          (rst),
      .speaker_i      (d_spk),
      .speaker_en_i   (d_spk_en),
      .ch_l_i         (d_ch_l),
      .ch_r_i         (d_ch_r),
      .ch_gain_i      (d_ch_gain),
      .ch_mute_i      (d_ch_mute),
      .audio_strobe_o (d_strobe),
      .sample_l_o     (d_sl),
      .sample_r_o     (d_sr),
      .sample_valid_o (d_valid),
      .clip_o         (d_clip)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // reference model state
   int unsigned m_l[NCH];
   int unsigned m_r[NCH];
   int unsigned m_g[NCH];
   bit          m_mute[NCH];
   bit          m_level = 1'b0;
   int          m_remain = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic apply_inputs();
      for (int k = 0; k < NCH; k++) begin
         ch_l[k*INW +: INW]  = m_l[k][INW-1:0];
         ch_r[k*INW +: INW]  = m_r[k][INW-1:0];
         ch_gain[k*3 +: 3]   = m_g[k][2:0];
         ch_mute[k]          = m_mute[k];
      end
   endtask

   task automatic set_all(input int unsigned l, input int unsigned r, input int unsigned g, input bit mu);
      for (int k = 0; k < NCH; k++) begin
         m_l[k] = l; m_r[k] = r; m_g[k] = g; m_mute[k] = mu;
      end
   endtask

   // sum of all unmuted channels, each scaled to full scale then shifted down
   function automatic int exp_side(input bit right, input int term);
      int s;
      s = term;
      for (int k = 0; k < NCH; k++) begin
         if (!m_mute[k]) s += ((right ? m_r[k] : m_l[k]) * (1 << (OUTW - INW))) >> m_g[k];
      end
      return s;
   endfunction

   task automatic toggle_spk();
      m_level  = !m_level;
      spk      = m_level;
      m_remain = HOLD;
   endtask

   // Wait for the next strobe, predict the sample, check latency and result.
   task automatic mix_one(input string tag, input bit toggle_at_strobe);
      bit got;
      int n, term, el, er;
      bit ec;
      got = 1'b0;
      for (int i = 0; i < 4 * F_DIV; i++) begin
         @(negedge clk);
         if (strobe) begin got = 1'b1; break; end
      end
      check({tag, " strobe_seen"}, 32'(got), 32'd1);
      if (!got) return;
      term = (spk_en && m_level && (m_remain > 0)) ? SPKLVL : 0;
      if (m_remain > 0) m_remain--;
      if (toggle_at_strobe) toggle_spk();
      el = exp_side(1'b0, term);
      er = exp_side(1'b1, term);
      ec = (el > 65535) || (er > 65535);
      if (el > 65535) el = 65535;
      if (er > 65535) er = 65535;
      n = 0;
      got = 1'b0;
      for (int i = 0; i < 2 * F_DIV; i++) begin
         @(negedge clk);
         n++;
         if (valid) begin got = 1'b1; break; end
      end
      check({tag, " latency"}, 32'(n), 32'(NCH + 3));
      check({tag, " sample_l"}, 32'(sl), 32'(el));
      check({tag, " sample_r"}, 32'(sr), 32'(er));
      check({tag, " clip"}, 32'(clip), 32'(ec));
   endtask

   initial begin
      int  n, n_valid;
      bit  saw_clip, nonzero, got, saw_valid;

      set_all(0, 0, 0, 1'b0);
      apply_inputs();
      repeat (3) @(negedge clk);
      check("rst sample_l", 32'(sl), 32'd0);
      check("rst sample_r", 32'(sr), 32'd0);
      check("rst valid", 32'(valid), 32'd0);
      check("rst clip", 32'(clip), 32'd0);
      check("rst strobe", 32'(strobe), 32'd0);
      check("rst dflt sample_l", 32'(d_sl), 32'd0);
      rst = 1'b0;

      // default parameters: strobe period and a silent mix
      n = 0;
      do begin @(negedge clk); n++; end while (!d_strobe && n < 2 * D_DIV);
      check("dflt first_strobe", 32'(n), 32'(D_DIV - 1));
      saw_clip = 1'b0; nonzero = 1'b0; n_valid = 0;
      for (int p = 0; p < 3; p++) begin
         n = 0;
         do begin
            @(negedge clk);
            n++;
            if (d_clip) saw_clip = 1'b1;
            if (d_valid) begin
               n_valid++;
               if (d_sl != '0 || d_sr != '0) nonzero = 1'b1;
            end
         end while (!d_strobe && n < 2 * D_DIV);
         check("dflt period", 32'(n), 32'(D_DIV));
      end
      check("dflt valid_count", 32'(n_valid), 32'd3);
      check("dflt clip_seen", 32'(saw_clip), 32'd0);
      check("dflt nonzero", 32'(nonzero), 32'd0);

      // saturation: ch0 full scale + ch1 half scale at gain 1
      set_all(0, 0, 0, 1'b1);
      m_l[0] = 'h3FF; m_mute[0] = 1'b0;
      m_l[1] = 'h200; m_g[1] = 1; m_mute[1] = 1'b0;
      apply_inputs();
      mix_one("sat", 1'b0);
      check("sat const_l", 32'(sl), 32'hFFFF);
      m_mute[0] = 1'b1;
      apply_inputs();
      mix_one("nosat", 1'b0);
      check("nosat const_l", 32'(sl), 32'h4000);

      // right-side gain
      set_all(0, 0, 0, 1'b1);
      m_r[2] = 'h100; m_g[2] = 3; m_mute[2] = 1'b0;
      apply_inputs();
      mix_one("gain3", 1'b0);
      check("gain3 const_r", 32'(sr), 32'h0800);

      // randomised channel mixes
      for (int t = 0; t < 24; t++) begin
         for (int k = 0; k < NCH; k++) begin
            m_l[k]    = $urandom_range(0, 1023);
            m_r[k]    = $urandom_range(0, 1023);
            m_g[k]    = $urandom_range(0, 7);
            m_mute[k] = ($urandom_range(0, 3) == 0);
         end
         apply_inputs();
         mix_one("rand", 1'b0);
      end

      // speaker pulse window
      set_all(0, 0, 0, 1'b1);
      apply_inputs();
      spk_en = 1'b1;
      toggle_spk();
      for (int t = 0; t < HOLD + 2; t++) mix_one("spk_rise", 1'b0);
      toggle_spk();
      for (int t = 0; t < HOLD - 1; t++) mix_one("spk_fall", 1'b0);
      mix_one("spk_coinc", 1'b1);
      for (int t = 0; t < HOLD + 2; t++) mix_one("spk_reload", 1'b0);

      // speaker disabled, then enabled mid-window
      spk_en = 1'b0;
      toggle_spk();
      mix_one("spk_off_a", 1'b0);
      toggle_spk();
      for (int t = 0; t < 4; t++) mix_one("spk_off_b", 1'b0);
      spk_en = 1'b1;
      for (int t = 0; t < 3; t++) mix_one("spk_on", 1'b0);

      // reset during ACCUM
      toggle_spk();
      m_l[0] = 'h3FF; m_r[0] = 'h155; m_mute[0] = 1'b0;
      apply_inputs();
      mix_one("pre_rst", 1'b0);
      got = 1'b0;
      for (int i = 0; i < 4 * F_DIV; i++) begin
         @(negedge clk);
         if (strobe) begin got = 1'b1; break; end
      end
      check("midrst strobe_seen", 32'(got), 32'd1);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst sample_l", 32'(sl), 32'd0);
      check("midrst sample_r", 32'(sr), 32'd0);
      check("midrst valid", 32'(valid), 32'd0);
      check("midrst clip", 32'(clip), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      m_remain = 0;
      n = 0; saw_valid = 1'b0;
      do begin
         @(negedge clk);
         n++;
         if (valid) saw_valid = 1'b1;
      end while (!strobe && n < 4 * F_DIV);
      check("midrst first_strobe", 32'(n), 32'(F_DIV - 1));
      check("midrst no_valid", 32'(saw_valid), 32'd0);
      check("midrst held_l", 32'(sl), 32'd0);
      mix_one("post_rst", 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
